// File: rtl/branch_predictor.sv
//==============================================================================
// Module   : branch_predictor
// Summary  : Direct-mapped dynamic branch predictor for the fetch stage:
//            2-bit counter, tag and target per entry. Optional statistics
//            counters are enabled with BRANCH_PREDICTOR_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    input  logic        flush,
    output logic        mispredict
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);

    localparam int c_DEPTH = 1 << IDX_W;

    logic [c_DEPTH-1:0] r_valid;
    logic [1:0]         r_ctr    [c_DEPTH];
    logic [TAG_W-1:0]   r_tag    [c_DEPTH];
    logic [31:0]        r_target [c_DEPTH];
    logic               r_mispredict;

    logic [IDX_W-1:0]   w_fetch_idx;
    logic [TAG_W-1:0]   w_fetch_tag;
    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic               w_mispredict;
    logic               w_unused_upd_pc;

    // Low PC bits and tag-excess bits of the update PC carry no information.
    assign w_unused_upd_pc = ^upd_pc;

    assign w_fetch_idx = fetch_pc[IDX_W+1:2];
    assign w_fetch_tag = fetch_pc[IDX_W+2 +: TAG_W];
    assign w_upd_idx   = upd_pc[IDX_W+1:2];
    assign w_upd_tag   = upd_pc[IDX_W+2 +: TAG_W];

    assign pred_hit    = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign pred_taken  = pred_hit && r_ctr[w_fetch_idx][1];
    assign pred_target = pred_taken ? r_target[w_fetch_idx] : (fetch_pc + 32'd4);

    assign w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_mispredict = upd_valid &&
                          ((upd_pred_taken != upd_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));

    // Flush wins over a same-cycle update; tags and targets are left stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_ctr[i]    <= 2'b01;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                if (upd_taken) begin
                    if (r_ctr[w_upd_idx] != 2'b11) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
                    end
                    r_target[w_upd_idx] <= upd_target;
                end else if (r_ctr[w_upd_idx] != 2'b00) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
                r_ctr[w_upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict <= 1'b0;
        end else begin
            r_mispredict <= w_mispredict;
        end
    end

    assign mispredict = r_mispredict;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (upd_valid) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (w_mispredict) begin
                r_stat_mispred <= r_stat_mispred + 32'd1;
            end
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//==============================================================================
// Module   : tb_branch_predictor
// Summary  : Directed self-checking bench for branch_predictor (stat ports
//            exercised when BRANCH_PREDICTOR_STATS_EN is defined).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush;
    logic        mispredict;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int tests = 0;
    int fails = 0;

    branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .flush           (flush),
        .mispredict      (mispredict)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one update for exactly one rising edge, then sample 3 ns later.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = taken;
        upd_target      = tgt;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
        #1;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #3;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic taken, input logic [31:0] tgt);
        fetch_pc = pc;
        #1;
        check({tag, "_hit"},    32'(pred_hit),   32'(hit));
        check({tag, "_taken"},  32'(pred_taken), 32'(taken));
        check({tag, "_target"}, pred_target,     tgt);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        idle_cycle();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        fetch_pc        = 32'h100;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        flush           = 1'b0;
        #1;
        lookup("reset", 32'h100, 1'b0, 1'b0, 32'h104);
        check("reset_mispredict", 32'(mispredict), 32'd0);
        idle_cycle();
        idle_cycle();
        rst_n = 1'b1;

`ifdef BRANCH_PREDICTOR_STATS_EN
        for (int i = 0; i < 10; i++) begin
            upd(32'h1000 + 32'(4 * i), 1'b0, 32'h0, (i < 3), 32'h0);
        end
        check("stat_branches_10", stat_branches, 32'd10);
        check("stat_mispred_3",   stat_mispred,  32'd3);
        rst_n = 1'b0;
        #1;
        check("stat_branches_rst", stat_branches, 32'd0);
        check("stat_mispred_rst",  stat_mispred,  32'd0);
        check("stat_rst_mispredict", 32'(mispredict), 32'd0);
        idle_cycle();
        rst_n = 1'b1;
        #1;
`endif

        // Allocation on a taken miss with a wrong direction prediction.
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        check("alloc_mispredict", 32'(mispredict), 32'd1);
        lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        idle_cycle();
        check("idle_mispredict", 32'(mispredict), 32'd0);

        // Counter walk: 10 -> 11 -> 11 -> 10 -> 01 -> 00.
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        check("ctr11a_mispredict", 32'(mispredict), 32'd0);
        lookup("ctr11a", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
        lookup("ctr11b", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        check("ctr10_mispredict", 32'(mispredict), 32'd1);
        lookup("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        lookup("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        check("ctr00_mispredict", 32'(mispredict), 32'd0);
        lookup("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);

        // Taken target mismatch alone is a mispredict; target is refreshed.
        upd(32'h100, 1'b1, 32'h240, 1'b1, 32'h200);
        check("tgt_mispredict", 32'(mispredict), 32'd1);
        lookup("ctr01_tgt", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h240, 1'b1, 32'h240);
        lookup("ctr10_tgt", 32'h100, 1'b1, 1'b1, 32'h240);

        // Not-taken miss leaves the table untouched.
        upd(32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup("nt_miss", 32'h104, 1'b0, 1'b0, 32'h108);

        // Alias 0x100 + (4 << 6) replaces the entry at index 0.
        upd(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

        // Same-cycle lookup/update: old contents until the edge.
        fetch_pc        = 32'h200;
        upd_valid       = 1'b1;
        upd_pc          = 32'h200;
        upd_taken       = 1'b0;
        upd_pred_taken  = 1'b1;
        upd_pred_target = 32'h300;
        #1;
        check("bypass_pre_taken", 32'(pred_taken), 32'd1);
        @(posedge clk);
        #2;
        upd_valid = 1'b0;
        #1;
        lookup("bypass_post", 32'h200, 1'b1, 1'b0, 32'h204);

        // Flush beats a simultaneous update; mispredict still computed.
        flush = 1'b1;
        upd(32'h100, 1'b1, 32'h500, 1'b1, 32'h200);
        flush = 1'b0;
        check("flush_mispredict", 32'(mispredict), 32'd1);
        lookup("flush_drop", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("flush_inv",  32'h200, 1'b0, 1'b0, 32'h204);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // After flush the counter restarts at 10 on allocation, then 01 -> not taken.
        upd(32'h100, 1'b1, 32'h600, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h600);
        lookup("post_flush_ctr01", 32'h100, 1'b1, 1'b0, 32'h104);

        // Asynchronous reset in the middle of an update cycle.
        upd(32'h100, 1'b1, 32'h600, 1'b0, 32'h0);
        check("pre_rst_mispredict", 32'(mispredict), 32'd1);
        upd_valid = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("async_rst_mispredict", 32'(mispredict), 32'd0);
        lookup("async_rst", 32'h100, 1'b0, 1'b0, 32'h104);
        idle_cycle();
        upd_valid = 1'b0;
        rst_n     = 1'b1;
        idle_cycle();
        lookup("after_rst", 32'h100, 1'b0, 1'b0, 32'h104);
        check("after_rst_mispredict", 32'(mispredict), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
